// File: rtl/fib_sequencer.sv
// ============================================================================
// fib_sequencer: drives the ALU with ADD/A/B and emits Fibonacci terms
// over a valid/ready handshake.  Rev 1.0
// ============================================================================
`default_nettype none

module fib_sequencer #(
  parameter int               WIDTH    = 8,
  parameter int               OP_W     = 3,
  parameter logic [OP_W-1:0]  ADD_CODE = 3'd4,
  parameter int               CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] f0,
  input  logic [WIDTH-1:0] f1,
  input  logic [CNT_W-1:0] len,
  output logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_c,
  output logic             term_valid,
  input  logic             term_ready,
  output logic [WIDTH-1:0] term_data,
  output logic [CNT_W-1:0] term_idx,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_last;

  assign w_last = (r_idx == (r_cnt - c_one));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = (len != '0) ? EMIT : DONE;
        end
      end
      EMIT: begin
        if (term_ready) begin
          w_state_next = w_last ? DONE : CALC;
        end
      end
      CALC:    w_state_next = EMIT;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ovf <= 1'b0;
            if (len != '0) begin
              r_a   <= f0;
              r_b   <= f1;
              r_cnt <= len;
              r_idx <= '0;
            end
          end
        end
        CALC: begin
          r_a   <= r_b;
          r_b   <= alu_c;
          r_idx <= r_idx + c_one;
          // A smaller sum means the addition wrapped past 2^WIDTH.
          if (alu_c < r_b) begin
            r_ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_op     = ADD_CODE;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign term_valid = (r_state == EMIT);
  assign term_data  = r_a;
  assign term_idx   = r_idx;
  assign busy       = (r_state == EMIT) || (r_state == CALC);
  assign done       = (r_state == DONE);
  assign ovf        = r_ovf;

endmodule

`default_nettype wire
